data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data memory for the MEM stage of the pipelined datapath.
- Writes are synchronous to Clk.
- Reads are asynchronous (combinational) when enabled.
- Byte address in, 32-bit word data in/out; the two low address bits are ignored, so all accesses are word-aligned.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- INDEX_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-low reset. Sampled on rising Clk; 0 = reset.
- Address  input  32  byte address. Word index = Address[INDEX_W+1:2]; bits [1:0] and bits above INDEX_W+1 are ignored.
- WriteData  input  32  data written to the addressed word when MemWrite=1.
- MemWrite  input  1  write enable, active-high.
- MemRead  input  1  read enable, active-high.
- ReadData  output  32  addressed word when MemRead=1, else 32'h00000000.

Behaviour:
- Storage: DEPTH x 32-bit registers, mem[0..DEPTH-1].
- Reset:
  - On rising Clk with Rst=0, every word is cleared to 32'h00000000.
  - Reset has priority over MemWrite; no write occurs in a reset cycle.
  - After reset, ReadData = 0 for any address, whether MemRead is 0 or 1.
- Write:
  - On rising Clk with Rst=1 and MemWrite=1: mem[idx] <= WriteData, where idx = Address[INDEX_W+1:2].
  - Write latency 1 edge. Full-word writes only; no byte enables.
- Read:
  - Combinational, zero latency: ReadData = MemRead ? mem[idx] : 32'h0.
  - Changes immediately with Address or MemRead, and after any edge that updates mem[idx].
- Misalignment: Address[1:0] ignored.
  - Addresses 0x0, 0x1, 0x2, 0x3 all select word 0.
  - Address 0x6 selects word 1.
  - No error or trap is raised.
- Out of range: upper address bits are discarded, so addresses wrap modulo DEPTH*4 bytes. For example, 0x00001000 selects word 0 when DEPTH=1024.
- Simultaneous MemRead=1 and MemWrite=1, same word:
  - Before the edge, ReadData shows the old contents.
  - After the edge, ReadData shows WriteData. No bypass.
- MemWrite=0: memory is unchanged regardless of WriteData or Address.
- Both enables low: ReadData = 0 and memory holds.
- Reset asserted mid-sequence: contents are cleared at that edge. Pending write data in that cycle is discarded.
- No X propagation: after reset, every output bit is always 0/1.

Test Plan:
- Reset:
  - Stimulus: Rst=0 for 2 edges, then Rst=1; MemRead=1 and sweep Address 0x0, 0x4, 0xFFC.
  - Required: ReadData = 0x00000000 for every address.
- Write/read-back:
  - Stimulus: write 0x12345678@0x0, 0x0000FFFF@0x4, 0xFFFFFFFF@0x8 (MemWrite=1, MemRead=0); then MemRead=1, MemWrite=0.
  - Required: reading 0x0 returns 0x12345678, 0x4 returns 0x0000FFFF, 0x8 returns 0xFFFFFFFF. ReadData = 0 while MemRead=0.
- Misaligned alias:
  - Stimulus: after the previous scenario, write 0x0000000F@0x2; then read Address 0x0, then 0x6.
  - Required: 0x0 returns 0x0000000F (word 0 overwritten); 0x6 returns 0x0000FFFF.
- Read-during-write, same word:
  - Stimulus: word 3 holds 0xAAAA5555; MemRead=1, MemWrite=1, Address=0xC, WriteData=0x5A5A5A5A.
  - Required: ReadData = 0xAAAA5555 before the edge and 0x5A5A5A5A after it.
- Reset priority and wrap:
  - Stimulus (a): Rst=0 together with MemWrite=1, WriteData=0x1, Address=0x10.
  - Required (a): word 4 reads 0 afterwards.
  - Stimulus (b): write 0xDEADBEEF@0x00001000.
  - Required (b): Address 0x0 reads 0xDEADBEEF.
- Write gating:
  - Stimulus: MemWrite=0, WriteData toggles over 3 edges at Address 0x8 (holding 0xFFFFFFFF).
  - Required: ReadData remains 0xFFFFFFFF.

Source files
------------

// File: rtl/data_memory_if.sv
// Bus between the MEM stage and the word-organised data memory.
// The master (datapath) drives address, data and enables; the slave returns ReadData combinationally.
interface data_memory_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    // No valid/ready handshake: MemWrite commits on the next rising Clk,
    // MemRead qualifies ReadData in the same cycle. Neither can be stalled.
    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage: synchronous full-word writes,
// asynchronous reads, byte address with the two low bits ignored.
module data_memory #(
    parameter int DEPTH   = 1024,
    parameter int INDEX_W = 10
) (
    input  logic          Clk,
    input  logic          Rst,
    data_memory_if.slave  memBus
);

    logic [31:0]        mem [DEPTH];
    logic [INDEX_W-1:0] wordIndex;
    logic               unusedAddrBits;

    // Upper bits are dropped so addresses wrap modulo DEPTH*4 bytes.
    assign wordIndex      = memBus.Address[INDEX_W+1:2];
    assign unusedAddrBits = ^{memBus.Address[31:INDEX_W+2], memBus.Address[1:0]};

    // Reset wins over a write issued in the same cycle.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memBus.MemWrite) begin
            mem[wordIndex] <= memBus.WriteData;
        end
    end

    // No write bypass: a same-word write shows up only after the edge.
    always_comb begin
        memBus.ReadData = '0;
        if (memBus.MemRead) begin
            memBus.ReadData = mem[wordIndex];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios then random traffic
// compared against an associative-array reference model.
module tb_data_memory;

    localparam int DEPTH   = 1024;
    localparam int INDEX_W = 10;

    logic Clk;
    logic Rst;

    data_memory_if memBus();

    data_memory #(.DEPTH(DEPTH), .INDEX_W(INDEX_W)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .memBus (memBus.slave)
    );

    // Clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [int];

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the memory is a sparse map of word number -> value;
    // an absent word reads as zero.
    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic re);
        if (!re) return 32'h0;
        if (model_mem.exists(word_of(addr))) return model_mem[word_of(addr)];
        return 32'h0;
    endfunction

    // One bus cycle: drive at negedge, check read before the edge, update the
    // model at the edge, check the same read again just after it.
    task automatic drive_cycle(input logic rst, input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input string tag);
        @(negedge Clk);
        Rst              = rst;
        memBus.MemWrite  = we;
        memBus.MemRead   = re;
        memBus.Address   = addr;
        memBus.WriteData = wdata;
        #1;
        exp_q.push_back(model_read(addr, re));
        check_val({tag, "_pre"}, memBus.ReadData, exp_q.pop_front());
        @(posedge Clk);
        if (!rst) model_mem.delete();
        else if (we) model_mem[word_of(addr)] = wdata;
        #1;
        exp_q.push_back(model_read(addr, re));
        check_val({tag, "_post"}, memBus.ReadData, exp_q.pop_front());
    endtask

    task automatic read_at(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(negedge Clk);
        Rst             = 1'b1;
        memBus.MemWrite = 1'b0;
        memBus.MemRead  = 1'b1;
        memBus.Address  = addr;
        #1;
        check_val(tag, memBus.ReadData, exp);
        check_val({tag, "_model"}, memBus.ReadData, model_read(addr, 1'b1));
    endtask

    initial begin
        Rst              = 1'b0;
        memBus.Address   = '0;
        memBus.WriteData = '0;
        memBus.MemWrite  = 1'b0;
        memBus.MemRead   = 1'b0;

        // Reset for two edges, then sweep reads
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "rst0");
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, "rst1");
        read_at(32'h0,   32'h0, "rst_rd_0");
        read_at(32'h4,   32'h0, "rst_rd_4");
        read_at(32'hFFC, 32'h0, "rst_rd_ffc");

        // Write / read-back
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678, "wr0");
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h4, 32'h0000FFFF, "wr4");
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, "wr8");
        read_at(32'h0, 32'h12345678, "rb_0");
        read_at(32'h4, 32'h0000FFFF, "rb_4");
        read_at(32'h8, 32'hFFFFFFFF, "rb_8");

        // Misaligned alias
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h2, 32'h0000000F, "wr_mis2");
        read_at(32'h0, 32'h0000000F, "mis_rd_0");
        read_at(32'h6, 32'h0000FFFF, "mis_rd_6");

        // Read during write, same word
        drive_cycle(1'b1, 1'b1, 1'b0, 32'hC, 32'hAAAA5555, "wr_c");
        @(negedge Clk);
        memBus.MemRead   = 1'b1;
        memBus.MemWrite  = 1'b1;
        memBus.Address   = 32'hC;
        memBus.WriteData = 32'h5A5A5A5A;
        #1;
        check_val("rdw_before", memBus.ReadData, 32'hAAAA5555);
        @(posedge Clk);
        model_mem[3] = 32'h5A5A5A5A;
        #1;
        check_val("rdw_after", memBus.ReadData, 32'h5A5A5A5A);

        // Reset priority over write
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h77, "wr_10");
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h1, "rst_wr");
        read_at(32'h10, 32'h0, "rstpri_rd_10");
        read_at(32'h8,  32'h0, "rstpri_rd_8");

        // Wrap
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h00001000, 32'hDEADBEEF, "wr_wrap");
        read_at(32'h0, 32'hDEADBEEF, "wrap_rd_0");

        // Write gating
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, "gate_wr");
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 32'h8, $urandom, "gate");
        end
        read_at(32'h8, 32'hFFFFFFFF, "gate_rd");

        // Both enables low
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, "idle");

        // Random traffic over a small set of words, with wrapped aliases
        for (int i = 0; i < 400; i++) begin
            logic [31:0] addr;
            addr = {$urandom_range(0, 7) << 12} | ($urandom_range(0, 15) << 2)
                 | ($urandom_range(0, 1) ? (32'((DEPTH - 1) * 4)) : 32'h0)
                 | 32'($urandom_range(0, 3));
            drive_cycle(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), addr, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
